negate_arbiter: RTL

- Shares one WIDTH-bit two's-complement negation/absolute-value datapath between two requesters.
- Round-robin arbitration; valid/ready handshakes on both request ports and on the result port.
- One registered result slot, so a result appears 1 cycle after its request is accepted.
- Sits between the switch/input logic and the display/consumer logic of the signed-arithmetic lab datapath.

---
 rtl/negate_arbiter_pkg.sv | 25 ++
 rtl/negate_arbiter_rr_arb2.sv | 34 +++
 rtl/negate_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/negate_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : negate_arbiter_pkg
// Purpose : Shared constants for the negate/abs arbiter: operation codes,
//           result-slot state encoding and the completion-counter width.
// Ports   : none (package)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package negate_arbiter_pkg;

  // Operation select carried on reqN_op
  localparam logic OP_NEG = 1'b0;
  localparam logic OP_ABS = 1'b1;

  // Result-slot state encoding
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Width of the completed-handshake counter
  localparam int DONE_CNT_W = 16;

endpackage : negate_arbiter_pkg

`default_nettype wire

// File: rtl/negate_arbiter_rr_arb2.sv
//------------------------------------------------------------------------------
// Module  : rr_arb2
// Purpose : Combinational two-way round-robin picker. A lone valid requester
//           always wins; under contention the requester that did NOT win
//           last time is chosen.
// Ports   : i_valid0/i_valid1 - requester valids
//           i_last_grant      - id of the most recent grant
//           o_grant           - chosen requester id (0 when none valid)
//           o_any_valid       - at least one requester is valid
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_grant,
  output logic o_any_valid
);

  always_comb begin
    o_any_valid = i_valid0 | i_valid1;
    if (i_valid0 && i_valid1) begin
      o_grant = ~i_last_grant;
    end else begin
      // Single (or no) requester: requester 1 only when it alone is valid
      o_grant = i_valid1;
    end
  end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/negate_arbiter.sv
//------------------------------------------------------------------------------
// Module  : negate_arbiter
// Purpose : Shares one two's-complement negate / absolute-value datapath
//           between two valid/ready requesters with round-robin arbitration.
//           A single registered result slot gives a fixed 1-cycle latency and
//           supports back-to-back results while the consumer keeps taking.
// Ports   : clk, rst_n                  - clock, async active-low reset
//           reqN_valid/op/data/ready     - requester N handshake (N = 0,1)
//           res_valid/data/ovf/id/ready  - result handshake
//           done_cnt                     - completed result handshakes (wraps)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module negate_arbiter
  import negate_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req0_op,
  input  logic [WIDTH-1:0]      req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_op,
  input  logic [WIDTH-1:0]      req1_data,
  output logic                  req1_ready,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_data,
  output logic                  res_ovf,
  output logic                  res_id,
  input  logic                  res_ready,
  output logic [DONE_CNT_W-1:0] done_cnt
);

  localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] C_MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  logic [0:0]            r_state;
  logic                  r_last_grant;
  logic [WIDTH-1:0]      r_res_data;
  logic                  r_res_ovf;
  logic                  r_res_id;
  logic [DONE_CNT_W-1:0] r_done_cnt;

  logic                  w_grant;
  logic                  w_any_valid;
  logic                  w_can_accept;
  logic                  w_accept;
  logic                  w_res_hs;
  logic                  w_sel_op;
  logic [WIDTH-1:0]      w_sel_data;
  logic [WIDTH-1:0]      w_neg;
  logic                  w_ovf;
  logic [WIDTH-1:0]      w_result;

  rr_arb2 u_rr_arb2 (
    .i_valid0     (req0_valid),
    .i_valid1     (req1_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_any_valid  (w_any_valid)
  );

  // The slot can take a new result when empty, or when the current one is
  // being consumed this very cycle (back-to-back without a bubble).
  assign w_can_accept = (r_state == ST_EMPTY) || ((r_state == ST_FULL) && res_ready);
  assign w_accept     = w_can_accept && w_any_valid;
  assign w_res_hs     = (r_state == ST_FULL) && res_ready;

  assign req0_ready = w_accept && (w_grant == 1'b0);
  assign req1_ready = w_accept && (w_grant == 1'b1);

  // Shared datapath operates on the granted requester's operands
  assign w_sel_op   = w_grant ? req1_op   : req0_op;
  assign w_sel_data = w_grant ? req1_data : req0_data;

  always_comb begin
    w_neg = ~w_sel_data + WIDTH'(1);
    // Only the most-negative value has no positive counterpart; both ops
    // negate it (abs of a negative operand is its negation).
    w_ovf = (w_sel_data == C_MOST_NEG);
    if (w_ovf) begin
      w_result = SAT ? C_MOST_POS : C_MOST_NEG;
    end else if ((w_sel_op == OP_ABS) && !w_sel_data[WIDTH-1]) begin
      w_result = w_sel_data;
    end else begin
      w_result = w_neg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_last_grant <= 1'b1;
      r_res_data   <= '0;
      r_res_ovf    <= 1'b0;
      r_res_id     <= 1'b0;
      r_done_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_state      <= ST_FULL;
        r_last_grant <= w_grant;
        r_res_data   <= w_result;
        r_res_ovf    <= w_ovf;
        r_res_id     <= w_grant;
      end else if (w_res_hs) begin
        // Result payload is left stale; only the valid flag drops
        r_state <= ST_EMPTY;
      end

      if (w_res_hs) begin
        r_done_cnt <= r_done_cnt + DONE_CNT_W'(1);
      end
    end
  end

  assign res_valid = (r_state == ST_FULL);
  assign res_data  = r_res_data;
  assign res_ovf   = r_res_ovf;
  assign res_id    = r_res_id;
  assign done_cnt  = r_done_cnt;

endmodule : negate_arbiter

`default_nettype wire
